// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core: FSM encoding of the
// PC unit, datapath width, and opcode values shared with the control unit.
package mips_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  function automatic logic is_word_aligned(input logic [WORD_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mips_next_pc.sv
// Combinational next-PC selection: sequential, branch, jump and jump-register
// targets with priority jr > jump > taken branch > pc+4.
module mips_next_pc
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] i_pc,
  input  logic              i_branch,
  input  logic              i_zero,
  input  logic              i_jump,
  input  logic              i_jr,
  input  logic [WORD_W-1:0] i_sign_imm,
  input  logic [25:0]       i_instr_index,
  input  logic [WORD_W-1:0] i_jr_target,
  output logic [WORD_W-1:0] o_next_pc,
  output logic [WORD_W-1:0] o_pc_plus4
);

  logic [WORD_W-1:0] w_pc_plus4;
  logic [WORD_W-1:0] w_branch_tgt;
  logic [WORD_W-1:0] w_jump_tgt;

  assign w_pc_plus4   = i_pc + 32'd4;
  assign w_branch_tgt = w_pc_plus4 + (i_sign_imm << 2);
  assign w_jump_tgt   = {w_pc_plus4[31:28], i_instr_index, 2'b00};

  // Redirect priority mux
  always_comb begin
    o_next_pc = w_pc_plus4;
    if (i_jr) begin
      o_next_pc = i_jr_target;
    end else if (i_jump) begin
      o_next_pc = w_jump_tgt;
    end else if (i_branch && i_zero) begin
      o_next_pc = w_branch_tgt;
    end else begin
      o_next_pc = w_pc_plus4;
    end
  end

  assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/mips_pc_unit.sv
// Program counter stage: BOOT/RUN/HALT control, PC register, misaligned
// jump-register trap and retired-instruction counter.
module mips_pc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             branch,
  input  logic             zero,
  input  logic             jump,
  input  logic             jr,
  input  logic [31:0]      sign_imm,
  input  logic [25:0]      instr_index,
  input  logic [31:0]      jr_target,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             pc_valid,
  output logic             halted,
  output logic             misalign,
  output logic [CNT_W-1:0] instr_count
);

  pc_state_e         r_state;
  logic [31:0]       r_pc;
  logic [CNT_W-1:0]  r_count;
  logic              r_misalign;
  logic [31:0]       w_next_pc;
  logic [31:0]       w_pc_plus4;

  mips_next_pc u_next_pc (
    .i_pc          (r_pc),
    .i_branch      (branch),
    .i_zero        (zero),
    .i_jump        (jump),
    .i_jr          (jr),
    .i_sign_imm    (sign_imm),
    .i_instr_index (instr_index),
    .i_jr_target   (jr_target),
    .o_next_pc     (w_next_pc),
    .o_pc_plus4    (w_pc_plus4)
  );

  // FSM, PC register, trap flag and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_VECTOR;
      r_count    <= {CNT_W{1'b0}};
      r_misalign <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (halt_req) begin
            r_state <= ST_HALT;
          end else if (stall) begin
            r_state <= ST_RUN;
          end else if (!is_word_aligned(w_next_pc)) begin
            // Faulting instruction stays on pc for the trap handler
            r_state    <= ST_HALT;
            r_misalign <= 1'b1;
          end else begin
            r_pc    <= w_next_pc;
            r_count <= r_count + CNT_W'(1);
          end
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state <= ST_HALT;
        end
      endcase
    end
  end

  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign pc_valid    = (r_state == ST_RUN);
  assign halted      = (r_state == ST_HALT);
  assign misalign    = r_misalign;
  assign instr_count = r_count;

endmodule

// File: tb/tb_mips_pc_unit.sv
// Self-checking bench for mips_pc_unit: directed vector table, hand-written
// trap/wrap sequences and randomized traffic against a behavioural model.
module tb_mips_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, halt_req = 1'b0, branch = 1'b0, zero = 1'b0;
  logic        jump = 1'b0, jr = 1'b0;
  logic [31:0] sign_imm = 32'd0;
  logic [25:0] instr_index = 26'd0;
  logic [31:0] jr_target = 32'd0;

  logic [31:0] pc, pc_plus4, instr_count;
  logic        pc_valid, halted, misalign;
  logic [31:0] pc_b, pc_plus4_b;
  logic        pc_valid_b, halted_b, misalign_b;
  logic [3:0]  instr_count_b;

  always #5 clk = ~clk;

  mips_pc_unit #(.RESET_VECTOR(32'h0000_0000), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .halt_req(halt_req),
    .branch(branch), .zero(zero), .jump(jump), .jr(jr),
    .sign_imm(sign_imm), .instr_index(instr_index), .jr_target(jr_target),
    .pc(pc), .pc_plus4(pc_plus4), .pc_valid(pc_valid), .halted(halted),
    .misalign(misalign), .instr_count(instr_count)
  );

  mips_pc_unit #(.RESET_VECTOR(32'h0000_0000), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .halt_req(halt_req),
    .branch(branch), .zero(zero), .jump(jump), .jr(jr),
    .sign_imm(sign_imm), .instr_index(instr_index), .jr_target(jr_target),
    .pc(pc_b), .pc_plus4(pc_plus4_b), .pc_valid(pc_valid_b), .halted(halted_b),
    .misalign(misalign_b), .instr_count(instr_count_b)
  );

  int total = 0;
  int bad = 0;

  // Behavioural model: mode 0 = booting, 1 = running, 2 = stopped
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  bit          m_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_target();
    logic [31:0] seq;
    seq = m_pc + 32'd4;
    if (jr) return jr_target;
    if (jump) return {seq[31:28], instr_index, 2'b00};
    if (branch && zero) return seq + sign_imm * 32'd4;
    return seq;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pc = 32'd0; m_cnt = 32'd0; m_mis = 1'b0;
  endtask

  task automatic model_edge();
    logic [31:0] t;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (halt_req) m_mode = 2;
      else if (!stall) begin
        t = model_target();
        if (t % 4 != 0) begin
          m_mode = 2; m_mis = 1'b1;
        end else begin
          m_pc = t; m_cnt = m_cnt + 32'd1;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("pc_valid", {31'd0, pc_valid}, {31'd0, m_mode == 1});
    chk("halted", {31'd0, halted}, {31'd0, m_mode == 2});
    chk("misalign", {31'd0, misalign}, {31'd0, m_mis});
    chk("instr_count", instr_count, m_cnt);
    chk("instr_count_w4", {28'd0, instr_count_b}, {28'd0, m_cnt[3:0]});
    chk("pc_w4", pc_b, m_pc);
  endtask

  task automatic set_in(input bit s, input bit h, input bit b, input bit z, input bit j,
                        input bit r, input logic [31:0] imm, input logic [25:0] idx,
                        input logic [31:0] jt);
    stall = s; halt_req = h; branch = b; zero = z; jump = j; jr = r;
    sign_imm = imm; instr_index = idx; jr_target = jt;
  endtask

  task automatic clr_in();
    set_in(0, 0, 0, 0, 0, 0, 32'd0, 26'd0, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_in();
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare_all();
  endtask

  typedef struct {
    bit          s, h, b, z, j, r;
    logic [31:0] imm;
    logic [25:0] idx;
    logic [31:0] jt;
    logic [31:0] e_pc;
    bit          e_valid, e_halted;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[18];

  initial begin
    vecs[0]  = '{0,0,0,0,0,0, 32'd0, 26'd0, 32'd0,        32'h0000_0000, 1,0, 32'd0};
    vecs[1]  = '{0,0,0,0,0,0, 32'd0, 26'd0, 32'd0,        32'h0000_0004, 1,0, 32'd1};
    vecs[2]  = '{0,0,0,0,0,0, 32'd0, 26'd0, 32'd0,        32'h0000_0008, 1,0, 32'd2};
    vecs[3]  = '{0,0,0,0,0,0, 32'd0, 26'd0, 32'd0,        32'h0000_000C, 1,0, 32'd3};
    vecs[4]  = '{0,0,0,0,0,1, 32'd0, 26'd0, 32'h10,       32'h0000_0010, 1,0, 32'd4};
    vecs[5]  = '{0,0,1,1,0,0, 32'hFFFF_FFFE, 26'd0, 32'd0, 32'h0000_000C, 1,0, 32'd5};
    vecs[6]  = '{0,0,0,0,0,1, 32'd0, 26'd0, 32'h10,       32'h0000_0010, 1,0, 32'd6};
    vecs[7]  = '{0,0,1,0,0,0, 32'hFFFF_FFFE, 26'd0, 32'd0, 32'h0000_0014, 1,0, 32'd7};
    vecs[8]  = '{0,0,0,0,0,1, 32'd0, 26'd0, 32'h4000_0020, 32'h4000_0020, 1,0, 32'd8};
    vecs[9]  = '{0,0,0,0,1,0, 32'd0, 26'h100, 32'd0,      32'h4000_0400, 1,0, 32'd9};
    vecs[10] = '{0,0,0,0,0,1, 32'd0, 26'd0, 32'h4000_0020, 32'h4000_0020, 1,0, 32'd10};
    vecs[11] = '{0,0,1,1,1,1, 32'd4, 26'h100, 32'h80,     32'h0000_0080, 1,0, 32'd11};
    vecs[12] = '{0,0,0,0,0,1, 32'd0, 26'd0, 32'h8,        32'h0000_0008, 1,0, 32'd12};
    vecs[13] = '{1,0,1,1,1,1, 32'd4, 26'h100, 32'h80,     32'h0000_0008, 1,0, 32'd12};
    vecs[14] = '{1,0,0,0,0,0, 32'd0, 26'd0, 32'd0,        32'h0000_0008, 1,0, 32'd12};
    vecs[15] = '{1,0,0,0,0,0, 32'd0, 26'd0, 32'd0,        32'h0000_0008, 1,0, 32'd12};
    vecs[16] = '{1,1,0,0,0,0, 32'd0, 26'd0, 32'd0,        32'h0000_0008, 0,1, 32'd12};
    vecs[17] = '{0,0,1,1,1,0, 32'd8, 26'h3F, 32'd0,       32'h0000_0008, 0,1, 32'd12};

    // Directed table from a fresh reset
    do_reset();
    chk("rst_pc", pc, 32'd0);
    chk("rst_valid", {31'd0, pc_valid}, 32'd0);
    for (int i = 0; i < 18; i++) begin
      set_in(vecs[i].s, vecs[i].h, vecs[i].b, vecs[i].z, vecs[i].j, vecs[i].r,
             vecs[i].imm, vecs[i].idx, vecs[i].jt);
      step();
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].e_pc);
      chk($sformatf("vec%0d_valid", i), {31'd0, pc_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("vec%0d_halted", i), {31'd0, halted}, {31'd0, vecs[i].e_halted});
      chk($sformatf("vec%0d_cnt", i), instr_count, vecs[i].e_cnt);
    end

    // Misaligned jr trap, frozen afterwards, cleared by reset
    do_reset();
    step();
    set_in(0, 0, 0, 0, 0, 1, 32'd0, 26'd0, 32'h20);
    step();
    set_in(0, 0, 0, 0, 0, 1, 32'd0, 26'd0, 32'h0000_0102);
    step();
    chk("trap_misalign", {31'd0, misalign}, 32'd1);
    chk("trap_halted", {31'd0, halted}, 32'd1);
    chk("trap_pc", pc, 32'h20);
    set_in(0, 0, 1, 1, 1, 0, 32'd16, 26'h55, 32'd0);
    step();
    step();
    chk("trap_frozen_pc", pc, 32'h20);
    chk("trap_frozen_cnt", instr_count, 32'd1);
    do_reset();
    chk("trap_clear_mis", {31'd0, misalign}, 32'd0);
    chk("trap_clear_halt", {31'd0, halted}, 32'd0);

    // PC wraps past the top of the address space
    step();
    set_in(0, 0, 0, 0, 0, 1, 32'd0, 26'd0, 32'hFFFF_FFFC);
    step();
    chk("wrap_plus4", pc_plus4, 32'd0);
    clr_in();
    step();
    chk("wrap_pc", pc, 32'd0);

    // Narrow counter wraps after 16 retirements
    do_reset();
    step();
    repeat (17) step();
    chk("cnt4_wrap", {28'd0, instr_count_b}, 32'd1);
    chk("cnt32_17", instr_count, 32'd17);

    // Randomized traffic, re-reset at intervals so halts do not end the run
    for (int run = 0; run < 8; run++) begin
      do_reset();
      for (int c = 0; c < 120; c++) begin
        set_in(($urandom % 6) == 0, ($urandom % 80) == 0, $urandom % 2, $urandom % 2,
               ($urandom % 4) == 0, ($urandom % 6) == 0,
               (($urandom % 2) == 0) ? 32'($signed($urandom_range(0, 64)) - 32) : 32'($urandom),
               26'($urandom),
               (($urandom % 16) == 0) ? 32'($urandom) : {$urandom, 2'b00} >> 2 << 2);
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
